// File: rtl/mult_pkg.sv
// Shared types and sizing for the signed-product to BCD converter.
package mult_pkg;

  localparam int unsigned N_BITS    = 16;
  localparam int unsigned N_DIGITOS = 5;
  localparam int unsigned N_ITER    = 16;
  localparam int unsigned BCD_W     = 4 * N_DIGITOS;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [2:0] {
    ESPERAR,
    CARGAR,
    AJUSTAR,
    DESPLAZAR,
    TERMINAR
  } estado_t;

  typedef struct packed {
    logic             signo;
    logic [BCD_W-1:0] bcd;
  } resultado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble digit correction: add 3 (mod 16) when the digit is 5 or more.
module ajuste_bcd (
  input  logic [3:0] dig,
  output logic [3:0] dig_aj_c
);

  always_comb begin
    dig_aj_c = dig;
    if (dig >= 4'd5) dig_aj_c = dig + 4'd3;
  end

endmodule

// File: rtl/conversion_bcd.sv
// Converts a signed 16-bit product into sign + 5-digit BCD magnitude using
// a sequential shift-and-add-3 loop.
module conversion_bcd
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [N_BITS-1:0] Mult,
  output logic              signo,
  output logic [BCD_W-1:0]  bcd,
  output logic              busy,
  output logic              done
);

  estado_t            state_q, state_d;
  logic [N_BITS-1:0]  mult_q;
  logic [N_BITS-1:0]  mag_q;
  logic               neg_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt_q;
  resultado_t         res_q;
  logic               busy_d;
  logic               done_d;

  // One corrector per BCD digit of the scratch register.
  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_dig
    ajuste_bcd u_ajuste (
      .dig      (scratch_q[4*i +: 4]),
      .dig_aj_c (scratch_adj[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ESPERAR;
    else      state_q <= state_d;
  end

  // Next state plus registered-output decode.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ESPERAR:   if (valid) state_d = CARGAR;
      CARGAR:    state_d = AJUSTAR;
      AJUSTAR:   state_d = DESPLAZAR;
      DESPLAZAR: state_d = (cnt_q == CNT_W'(1)) ? TERMINAR : AJUSTAR;
      TERMINAR: begin
        state_d = ESPERAR;
        done_d  = 1'b1;
      end
      default:   state_d = ESPERAR;
    endcase
    busy_d = (state_d != ESPERAR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_q    <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      scratch_q <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      unique case (state_q)
        ESPERAR: if (valid) mult_q <= Mult;
        CARGAR: begin
          // 16'h8000 negates to itself, which is 32768 read as unsigned.
          neg_q     <= mult_q[N_BITS-1];
          mag_q     <= mult_q[N_BITS-1] ? (~mult_q + N_BITS'(1)) : mult_q;
          scratch_q <= '0;
          cnt_q     <= CNT_W'(N_ITER);
        end
        AJUSTAR:   scratch_q <= scratch_adj;
        DESPLAZAR: begin
          {scratch_q, mag_q} <= {scratch_q[BCD_W-2:0], mag_q, 1'b0};
          cnt_q              <= cnt_q - CNT_W'(1);
        end
        TERMINAR: begin
          res_q.bcd   <= scratch_q;
          res_q.signo <= neg_q;
        end
        default: ;
      endcase
    end
  end

  assign signo = res_q.signo;
  assign bcd   = res_q.bcd;

endmodule

// File: tb/tb_conversion_bcd.sv
// Scoreboard bench for conversion_bcd: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_conversion_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] Mult;
  logic        signo;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  conversion_bcd dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .Mult  (Mult),
    .signo (signo),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [19:0] b;
    int unsigned e;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_n = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endfunction

  function automatic logic [19:0] to_bcd(input int v);
    int          m;
    logic [19:0] r;
    m = (v < 0) ? -v : v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("signo", 32'(signo), 32'(x.s));
        chk("bcd", 32'(bcd), 32'(x.b));
        chk("done_edge", edge_n, x.e);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push(input logic s, input logic [19:0] b);
    exp_t x;
    x.s = s;
    x.b = b;
    x.e = edge_n + 35;
    sb.push_back(x);
  endtask

  task automatic drain();
    for (int c = 0; c < 120 && sb.size() != 0; c++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk);
  endtask

  // Single valid pulse; Mult is scrambled right after capture.
  task automatic run_one(input logic [15:0] m, input logic s, input logic [19:0] b);
    @(posedge clk); #1;
    valid = 1'b1;
    Mult  = m;
    push(s, b);
    @(posedge clk); #1;
    valid = 1'b0;
    Mult  = 16'($urandom);
    #1 chk("busy_after_capture", 32'(busy), 32'd1);
    drain();
  endtask

  initial begin
    rst   = 1'b0;
    valid = 1'b0;
    Mult  = '0;
    #12;
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_signo", 32'(signo), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_one(16'h0000, 1'b0, 20'h00000);
    run_one(16'hC080, 1'b1, 20'h16256);
    run_one(16'h4000, 1'b0, 20'h16384);
    run_one(16'h8000, 1'b1, 20'h32768);
    run_one(16'h7FFF, 1'b0, 20'h32767);
    run_one(16'h1234, 1'b0, 20'h04660);
    chk("hold_bcd", 32'(bcd), 32'h04660);

    // valid held for 40 cycles with Mult changing: captures at i=0 and i=35.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      if (i == 0) begin
        Mult = 16'h1234;
        push(1'b0, 20'h04660);
      end else if (i == 35) begin
        Mult = 16'hFFFF;
        push(1'b1, 20'h00001);
      end else begin
        Mult = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    drain();

    // Reset in the middle of a conversion: outputs clear, no done follows.
    @(posedge clk); #1;
    valid = 1'b1;
    Mult  = 16'h2222;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_signo", 32'(signo), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);

    run_one(16'hFF85, 1'b1, 20'h00123);

    // Signed 8x8 products with valid tied high: one result every 35 edges.
    for (int n = 0; n < 20; n++) begin
      int a, b, p;
      if (n == 0)      begin a = -128; b = -128; end
      else if (n == 1) begin a = -128; b = 127;  end
      else begin
        a = int'($signed(8'($urandom_range(0, 255))));
        b = int'($signed(8'($urandom_range(0, 255))));
      end
      p = a * b;
      if (n != 0) repeat (34) @(posedge clk);
      @(posedge clk); #1;
      valid = 1'b1;
      Mult  = 16'(p);
      push(p < 0, to_bcd(p));
    end
    @(posedge clk); #1;
    valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
